// File: rtl/palette_lookup_arbiter_pkg.sv
// Shared palette types and the power-on colour table for the sprite colour path.
package palette_pkg;
  localparam int PAL_ENTRIES = 8;

  typedef logic [11:0] color_t;
  typedef logic [2:0]  pal_idx_t;

  localparam color_t PALETTE_DEFAULT [PAL_ENTRIES] = '{
    12'h000, 12'hB00, 12'hCB1, 12'hFD0,
    12'h040, 12'h3FD, 12'h456, 12'h9CD
  };
endpackage

// File: rtl/palette_lookup_arbiter_if.sv
// Lookup request/response and palette configuration bundle between requesters and the arbiter.
interface palette_lookup_arbiter_if
  import palette_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 3,
  parameter int COLOR_W = 12
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*IDX_W-1:0] req_index;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [COLOR_W-1:0]       rsp_color;
  logic                     cfg_we;
  logic [IDX_W-1:0]         cfg_addr;
  logic [COLOR_W-1:0]       cfg_data;
  logic                     frame_sync;
  logic                     commit_pending;

  modport master (
    output req_valid, req_index, cfg_we, cfg_addr, cfg_data, frame_sync,
    input  req_ready, rsp_valid, rsp_color, commit_pending
  );

  modport slave (
    input  req_valid, req_index, cfg_we, cfg_addr, cfg_data, frame_sync,
    output req_ready, rsp_valid, rsp_color, commit_pending
  );
endinterface

// File: rtl/palette_lookup_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: scans upward from i_ptr with wrap, one-hot grant plus encoded id.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_id
);
  logic          w_found;
  logic [PW-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_id    = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(i_ptr) + k >= N) w_j = PW'(int'(i_ptr) + k - N);
      else                      w_j = PW'(int'(i_ptr) + k);
      if (!w_found && i_req[w_j]) begin
        w_found      = 1'b1;
        o_grant[w_j] = 1'b1;
        o_id         = w_j;
      end
    end
  end
endmodule

// File: rtl/palette_lookup_arbiter.sv
// Shared double-buffered palette: round-robin lookup grant, 2-stage read pipeline, frame-synced commit.
module palette_lookup_arbiter
  import palette_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 3,
  parameter int COLOR_W = 12
) (
  input  logic Clk,
  input  logic Reset_n,
  palette_lookup_arbiter_if.slave bus
);
  localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PAL_N = 2 ** IDX_W;

  logic [NUM_REQ-1:0] w_grant;
  logic [PW-1:0]      w_gnt_id;
  logic [IDX_W-1:0]   w_gnt_idx;

  logic [PW-1:0]      r_rr_ptr;
  logic               r_s1_valid;
  logic [PW-1:0]      r_s1_id;
  logic [IDX_W-1:0]   r_s1_idx;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [COLOR_W-1:0] r_rsp_color;
  logic               r_commit_pending;
  logic [COLOR_W-1:0] r_shadow [PAL_N];
  logic [COLOR_W-1:0] r_active [PAL_N];

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_id    (w_gnt_id)
  );

  assign w_gnt_idx          = bus.req_index[int'(w_gnt_id)*IDX_W +: IDX_W];
  // Grants are held off while in reset so no handshake can complete then.
  assign bus.req_ready      = Reset_n ? w_grant : '0;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_color      = r_rsp_color;
  assign bus.commit_pending = r_commit_pending;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rr_ptr    <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_id     <= '0;
      r_s1_idx    <= '0;
      r_rsp_valid <= '0;
      r_rsp_color <= '0;
    end else begin
      if (|w_grant) begin
        r_rr_ptr <= (w_gnt_id == PW'(NUM_REQ-1)) ? '0 : w_gnt_id + PW'(1);
        r_s1_id  <= w_gnt_id;
        r_s1_idx <= w_gnt_idx;
      end
      r_s1_valid  <= |w_grant;
      r_rsp_valid <= r_s1_valid ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << r_s1_id) : '0;
      // Read happens against the pre-edge active table, so a same-edge commit is not seen.
      if (r_s1_valid) r_rsp_color <= r_active[r_s1_idx];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_commit_pending <= 1'b0;
      for (int i = 0; i < PAL_N; i++) begin
        r_shadow[i] <= COLOR_W'(PALETTE_DEFAULT[i % PAL_ENTRIES]);
        r_active[i] <= COLOR_W'(PALETTE_DEFAULT[i % PAL_ENTRIES]);
      end
    end else begin
      if (bus.cfg_we) r_shadow[bus.cfg_addr] <= bus.cfg_data;
      if (bus.frame_sync) begin
        r_commit_pending <= 1'b0;
        // Forward a same-cycle shadow write straight into the committed table.
        for (int i = 0; i < PAL_N; i++) begin
          if (bus.cfg_we && bus.cfg_addr == IDX_W'(i)) r_active[i] <= bus.cfg_data;
          else                                         r_active[i] <= r_shadow[i];
        end
      end else if (bus.cfg_we) begin
        r_commit_pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Directed bench for palette_lookup_arbiter with a response scoreboard keyed on expected arrival cycle.
module tb_palette_lookup_arbiter;
  logic Clk = 1'b0;
  logic Reset_n;

  typedef struct {
    logic [3:0]  v;
    logic [11:0] c;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  palette_lookup_arbiter_if #(.NUM_REQ(4), .IDX_W(3), .COLOR_W(12)) bus ();

  palette_lookup_arbiter #(.NUM_REQ(4), .IDX_W(3), .COLOR_W(12)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, observed cycle=%0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  // Response monitor: every falling edge either matches the due scoreboard entry or expects silence.
  always @(negedge Clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      checks++;
      assert (bus.rsp_valid === e.v) else begin
        failures++;
        $error("FAIL rsp_valid observed=%b expected=%b cyc=%0d", bus.rsp_valid, e.v, cyc);
      end
      checks++;
      assert (bus.rsp_color === e.c) else begin
        failures++;
        $error("FAIL rsp_color observed=%h expected=%h cyc=%0d", bus.rsp_color, e.c, cyc);
      end
    end else begin
      checks++;
      assert (bus.rsp_valid === 4'b0000) else begin
        failures++;
        $error("FAIL rsp_idle observed=%b expected=0000 cyc=%0d", bus.rsp_valid, cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic lookup(input logic [3:0] v, input logic [11:0] idx,
                        input logic [3:0] eg, input logic [11:0] ec, input string tag);
    bus.req_valid = v;
    bus.req_index = idx;
    @(negedge Clk);
    chk({tag, "_ready"}, {8'h0, bus.req_ready}, {8'h0, eg});
    if (eg != 4'b0000) sb.push_back('{eg, ec, cyc + 2});
    @(posedge Clk); #1;
  endtask

  task automatic cfg(input logic we, input logic [2:0] addr, input logic [11:0] data, input logic fs);
    bus.req_valid  = '0;
    bus.cfg_we     = we;
    bus.cfg_addr   = addr;
    bus.cfg_data   = data;
    bus.frame_sync = fs;
    @(posedge Clk); #1;
    bus.cfg_we     = 1'b0;
    bus.frame_sync = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.req_valid = '0;
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    Reset_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n        = 1'b0;
    bus.req_valid  = '0;
    bus.req_index  = '0;
    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_data   = '0;
    bus.frame_sync = 1'b0;
    bus.req_valid  = 4'b1111;
    @(negedge Clk);
    chk("rst_ready", {8'h0, bus.req_ready}, 12'h000);
    chk("rst_color", bus.rsp_color, 12'h000);
    chk("rst_pending", {11'h0, bus.commit_pending}, 12'h000);
    do_reset();

    // Single lookup: requester 2, index 5.
    lookup(4'b0100, {3'd0, 3'd5, 3'd0, 3'd0}, 4'b0100, 12'h3FD, "single");
    idle(3);
    chk("idle_ready", {8'h0, bus.req_ready}, 12'h000);

    // All requesters continuously from reset.
    do_reset();
    lookup(4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, 4'b0001, 12'hB00, "rr0");
    lookup(4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, 4'b0010, 12'hCB1, "rr1");
    lookup(4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, 4'b0100, 12'hFD0, "rr2");
    lookup(4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, 4'b1000, 12'h040, "rr3");
    lookup(4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, 4'b0001, 12'hB00, "rr4");
    idle(3);

    // Shadow write is invisible until commit; lookup in S1 at the commit edge sees the old value.
    cfg(1'b1, 3'd1, 12'h0F0, 1'b0);
    chk("pending_set", {11'h0, bus.commit_pending}, 12'h001);
    lookup(4'b0001, {3'd0, 3'd0, 3'd0, 3'd1}, 4'b0001, 12'hB00, "pre_commit");
    cfg(1'b0, 3'd0, 12'h000, 1'b1);
    chk("pending_clr", {11'h0, bus.commit_pending}, 12'h000);
    lookup(4'b0001, {3'd0, 3'd0, 3'd0, 3'd1}, 4'b0001, 12'h0F0, "post_commit");
    idle(3);

    // Write forwarded into a same-cycle commit.
    cfg(1'b1, 3'd7, 12'h123, 1'b1);
    chk("fwd_pending", {11'h0, bus.commit_pending}, 12'h000);
    lookup(4'b0001, {3'd0, 3'd0, 3'd0, 3'd7}, 4'b0001, 12'h123, "fwd");
    idle(3);

    // Reset with a lookup in flight: response dropped, tables and pointer back to defaults.
    cfg(1'b1, 3'd1, 12'h777, 1'b0);
    chk("pending_pre_rst", {11'h0, bus.commit_pending}, 12'h001);
    lookup(4'b0001, {3'd0, 3'd0, 3'd0, 3'd1}, 4'b0001, 12'h0F0, "inflight");
    Reset_n = 1'b0;
    sb.delete();
    bus.req_valid = 4'b1111;
    @(negedge Clk);
    chk("rst_mid_ready", {8'h0, bus.req_ready}, 12'h000);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    chk("rst_mid_pending", {11'h0, bus.commit_pending}, 12'h000);
    lookup(4'b1111, {3'd0, 3'd0, 3'd0, 3'd1}, 4'b0001, 12'hB00, "after_rst");
    idle(3);

    // Lone requester 3 wraps the pointer; then 0 and 3 together favour 0.
    lookup(4'b1000, {3'd6, 3'd0, 3'd0, 3'd0}, 4'b1000, 12'h456, "wrap0");
    lookup(4'b1000, {3'd6, 3'd0, 3'd0, 3'd0}, 4'b1000, 12'h456, "wrap1");
    lookup(4'b1000, {3'd6, 3'd0, 3'd0, 3'd0}, 4'b1000, 12'h456, "wrap2");
    lookup(4'b1001, {3'd6, 3'd0, 3'd0, 3'd5}, 4'b0001, 12'h3FD, "pair0");
    lookup(4'b1000, {3'd6, 3'd0, 3'd0, 3'd5}, 4'b1000, 12'h456, "pair1");
    idle(4);

    chk("sb_drained", 12'(sb.size()), 12'h000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/palette_lookup_arbiter.md
Name: palette_lookup_arbiter

Overview:
- Shares one 8-entry RGB444 palette among NUM_REQ sprite/background requesters (player, enemies, bullets, background) in the VGA colour path.
- Round-robin arbitration grants one lookup per clock. The lookup pipeline returns the colour 2 cycles later, tagged with a one-hot requester valid.
- Palette is double-buffered. Software writes go to a shadow table, which is committed to the active table on a frame-sync pulse, so colours never change mid-frame.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- IDX_W, 3, palette index width (8 entries)
- COLOR_W, 12, output colour width (RGB444, red in [11:8])

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester lookup request
- req_index  in  NUM_REQ*IDX_W  requester i index in bits [i*IDX_W +: IDX_W]
- req_ready  out  NUM_REQ  one-hot grant; handshake completes when valid&ready
- rsp_valid  out  NUM_REQ  one-hot; colour on rsp_color belongs to this requester
- rsp_color  out  COLOR_W  looked-up colour
- cfg_we  in  1  shadow table write strobe
- cfg_addr  in  IDX_W  shadow entry address
- cfg_data  in  COLOR_W  shadow entry data
- frame_sync  in  1  single-cycle pulse (vsync start); commits shadow to active
- commit_pending  out  1  shadow differs from active since last commit

Behaviour:
- Reset (async, Reset_n=0): req_ready=0, rsp_valid=0, rsp_color=0, commit_pending=0, rr pointer=0, S1/S2 valids cleared. Shadow and active tables load PALETTE_DEFAULT: 0:000 1:B00 2:CB1 3:FD0 4:040 5:3FD 6:456 7:9CD. An in-flight lookup is dropped with no response.
- Arbitration is combinational, scanning from rr pointer upward with wrap. The first i with req_valid[i]=1 gets req_ready[i]=1; all others get 0. req_ready is 0 whenever no request is valid.
- On a grant of i, rr pointer becomes (i+1) mod NUM_REQ at the clock edge. With no grant, the pointer holds.
- Requester must hold req_valid and req_index stable until granted. Dropping valid before grant is allowed; no lookup is issued.
- Stage S1 (edge after handshake) registers grant id and index; s1_valid=1.
- Stage S2 (next edge) reads the active table at the S1 index and registers rsp_color. rsp_valid is one-hot of the S1 id.
- Latency: exactly 2 clocks from the handshake edge to rsp_valid. Throughput is 1 lookup/clock and there is no backpressure.
- When S2 is idle, rsp_valid=0 and rsp_color holds its last value.
- Config write: cfg_we=1 writes shadow[cfg_addr]=cfg_data at the edge and sets commit_pending=1. The active table is unaffected.
- Commit on frame_sync=1: active <= shadow at the edge, and commit_pending=0.
- cfg_we and frame_sync in the same cycle: the commit includes that write (forwarded), and commit_pending=0.
- A lookup in S1 during the commit edge reads the pre-commit active value. The next lookup reads post-commit values.
- frame_sync held for more than one cycle is harmless; the commit repeats.
- Arbitration continues uninterrupted during config writes and commits.

Decomposition:
- Package palette_pkg: typedef color_t (logic [11:0]), typedef pal_idx_t (logic [2:0]), PALETTE_DEFAULT constant array, PAL_ENTRIES=8.
- One sub-module, rr_arbiter (parameter N, inputs req/ptr, output one-hot grant plus encoded id), reusable by other shared sprite resources.
- Tables and pipeline live in the top module.

Test Plan:
- Reset then req_valid[2]=1, index=5 -> req_ready=0100 the same cycle; 2 clocks later rsp_valid=0100, rsp_color=3FD.
- All 4 requesting continuously from reset -> grants cycle 0,1,2,3,0; responses in the same order 2 cycles behind; no bubbles.
- cfg_we addr=1 data=0F0, then lookup index 1 -> B00 and commit_pending=1. Pulse frame_sync, then lookup -> 0F0 and commit_pending=0.
- cfg_we addr=7 data=123 together with frame_sync, then lookup index 7 -> 123; commit_pending=0.
- Lookup granted, then Reset_n asserted for 1 cycle before the response -> no rsp_valid; tables back to defaults (index 1 -> B00); rr pointer=0.
- req_valid[3] only, 3 consecutive grants -> pointer wraps to 0. Then req 0 and 3 together -> grant 0 first.
